hdd_sd_bridge: RTL and testbench

Sector-transfer bridge between the IIgs hard-disk controller and hps_io virtual drive 0. It turns single-cycle sector read/write requests into the hps_io `sd_rd`/`sd_wr`/`sd_ack` handshake and holds a 512-byte sector buffer shared by the SD side and the controller side. It stalls the CPU through `cpu_wait` for the whole transfer. It replaces the ad-hoc HDD request logic in the emu top level and adds latched LBA, one-deep request queueing, and error reporting.

---
 rtl/hdd_sd_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_hdd_sd_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdd_sd_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdd_sd_bridge: IIgs HDD controller <-> hps_io drive 0 sector bridge with   |
// | 512-byte shared buffer, one-deep request queue and error reporting.        |
// | Optional HDD_TIMEOUT_EN adds a per-transfer abort counter.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hdd_sd_bridge #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic [31:0] hdd_lba,
    input  logic        hdd_mounted,
    input  logic        hdd_protect,
    output logic        cpu_wait,
    output logic        hdd_done,
    output logic        hdd_error,
    input  logic [8:0]  hdd_ram_addr,
    input  logic [7:0]  hdd_ram_di,
    input  logic        hdd_ram_we,
    output logic [7:0]  hdd_ram_do,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        cpu_wait_q, cpu_wait_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        fin_err_q, fin_err_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic        pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] pend_lba_q, pend_lba_d;
    logic        ack_q, ack_d;
    logic        ign_q, ign_d;
`ifdef HDD_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
`else
    wire         w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic        w_live_req, w_live_wr, w_sel_wr, w_bad, w_accept;
    logic        w_ack_rise, w_ack_fall, w_sd_we, w_ctl_we;
    logic [31:0] w_sel_lba;

    // A pending request always outranks a live one; read wins over write.
    assign w_live_req = hdd_read | hdd_write;
    assign w_live_wr  = hdd_write & ~hdd_read;
    assign w_sel_wr   = pend_q ? pend_wr_q  : w_live_wr;
    assign w_sel_lba  = pend_q ? pend_lba_q : hdd_lba;
    assign w_bad      = ~hdd_mounted | (w_sel_wr & hdd_protect);

    // ign_q masks acks left over from a request aborted by reset or timeout.
    assign w_ack_rise = sd_ack & ~ack_q & ~ign_q;
    assign w_ack_fall = ~sd_ack & ack_q & ~ign_q;

    assign w_sd_we  = sd_buff_wr & sd_ack & ~ign_q & ((state_q == S_REQ) || (state_q == S_XFER));
    assign w_ctl_we = hdd_ram_we & (state_q == S_IDLE);

    always_comb begin
        state_d    = state_q;
        cpu_wait_d = cpu_wait_q;
        done_d     = 1'b0;
        error_d    = error_q;
        fin_err_d  = fin_err_q;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        sd_lba_d   = sd_lba_q;
        pend_d     = pend_q;
        pend_wr_d  = pend_wr_q;
        pend_lba_d = pend_lba_q;
        ack_d      = sd_ack;
        ign_d      = ign_q & sd_ack;
        w_accept   = 1'b0;
`ifdef HDD_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        // A request taken straight out of FIN clears the status one cycle
        // after the done pulse so the pulse still carries its own status.
        if (done_q && cpu_wait_q)
            error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_live_req) begin
                    w_accept = 1'b1;
                    error_d  = 1'b0;
                end
            end
            S_REQ: begin
                if (w_ack_rise) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (w_ack_fall) begin
                    fin_err_d = 1'b0;
                    state_d   = S_FIN;
                end
            end
            default: begin
                done_d  = 1'b1;
                error_d = fin_err_q;
                if (pend_q || w_live_req) begin
                    w_accept = 1'b1;
                end else begin
                    cpu_wait_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
        endcase

        if ((state_q == S_REQ) || (state_q == S_XFER)) begin
            if (w_live_req && !pend_q) begin
                pend_d     = 1'b1;
                pend_wr_d  = w_live_wr;
                pend_lba_d = hdd_lba;
            end
`ifdef HDD_TIMEOUT_EN
            tmo_d = tmo_q + 24'd1;
            if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                sd_rd_d   = 1'b0;
                sd_wr_d   = 1'b0;
                fin_err_d = 1'b1;
                ign_d     = 1'b1;
                state_d   = S_FIN;
            end
`endif
        end

        if (w_accept) begin
            sd_lba_d   = w_sel_lba;
            cpu_wait_d = 1'b1;
            pend_d     = 1'b0;
`ifdef HDD_TIMEOUT_EN
            tmo_d      = 24'd0;
`endif
            if (w_bad) begin
                fin_err_d = 1'b1;
                state_d   = S_FIN;
            end else begin
                sd_rd_d   = ~w_sel_wr;
                sd_wr_d   = w_sel_wr;
                fin_err_d = 1'b0;
                state_d   = S_REQ;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cpu_wait_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fin_err_q  <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            sd_lba_q   <= 32'd0;
            pend_q     <= 1'b0;
            pend_wr_q  <= 1'b0;
            pend_lba_q <= 32'd0;
            ack_q      <= 1'b0;
            ign_q      <= 1'b1;
`ifdef HDD_TIMEOUT_EN
            tmo_q      <= 24'd0;
`endif
        end else begin
            state_q    <= state_d;
            cpu_wait_q <= cpu_wait_d;
            done_q     <= done_d;
            error_q    <= error_d;
            fin_err_q  <= fin_err_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            sd_lba_q   <= sd_lba_d;
            pend_q     <= pend_d;
            pend_wr_q  <= pend_wr_d;
            pend_lba_q <= pend_lba_d;
            ack_q      <= ack_d;
            ign_q      <= ign_d;
`ifdef HDD_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Single write port (SD side has priority), two registered read ports.
    logic [7:0] buf_mem [0:511];
    logic [7:0] hdd_ram_do_q;
    logic [7:0] sd_buff_din_q;

    always_ff @(posedge clk_sys) begin
        if (w_sd_we)
            buf_mem[sd_buff_addr] <= sd_buff_dout;
        else if (w_ctl_we)
            buf_mem[hdd_ram_addr] <= hdd_ram_di;
        hdd_ram_do_q  <= buf_mem[hdd_ram_addr];
        sd_buff_din_q <= buf_mem[sd_buff_addr];
    end

    assign cpu_wait    = cpu_wait_q;
    assign hdd_done    = done_q;
    assign hdd_error   = error_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_lba      = sd_lba_q;
    assign hdd_ram_do  = hdd_ram_do_q;
    assign sd_buff_din = sd_buff_din_q;

endmodule
`default_nettype wire

// File: tb/tb_hdd_sd_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hdd_sd_bridge: directed self-checking bench for hdd_sd_bridge.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hdd_sd_bridge;

`ifdef HDD_TIMEOUT_EN
    localparam logic [23:0] c_tmo = 24'd100;
`else
    localparam logic [23:0] c_tmo = 24'd14_000_000;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        hdd_read = 1'b0, hdd_write = 1'b0;
    logic [31:0] hdd_lba = 32'd0;
    logic        hdd_mounted = 1'b1, hdd_protect = 1'b0;
    logic        cpu_wait, hdd_done, hdd_error;
    logic [8:0]  hdd_ram_addr = 9'd0;
    logic [7:0]  hdd_ram_di = 8'd0;
    logic        hdd_ram_we = 1'b0;
    logic [7:0]  hdd_ram_do;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_dout = 8'd0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;

    int n_vec = 0;
    int n_err = 0;
    logic cw_drop;

    hdd_sd_bridge #(.TIMEOUT_CYCLES(c_tmo)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .hdd_read(hdd_read), .hdd_write(hdd_write), .hdd_lba(hdd_lba),
        .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
        .cpu_wait(cpu_wait), .hdd_done(hdd_done), .hdd_error(hdd_error),
        .hdd_ram_addr(hdd_ram_addr), .hdd_ram_di(hdd_ram_di), .hdd_ram_we(hdd_ram_we),
        .hdd_ram_do(hdd_ram_do), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // {cpu_wait, hdd_done, hdd_error, sd_rd, sd_wr}
    function automatic logic [4:0] flags();
        return {cpu_wait, hdd_done, hdd_error, sd_rd, sd_wr};
    endfunction

    initial begin
        #2;
        check("reset_flags", {27'd0, flags()}, 32'd0);
        check("reset_lba", sd_lba, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Read: lba 0x1234, SD fills addr^0x5A
        hdd_read = 1'b1; hdd_lba = 32'h1234;
        tick();
        hdd_read = 1'b0;
        check("rd_lba", sd_lba, 32'h1234);
        check("rd_flags", {27'd0, flags()}, 32'b10010);
        tick(); tick();
        sd_ack = 1'b1;
        tick();
        check("rd_ack_drop", {31'd0, sd_rd}, 32'd0);
        for (int a = 0; a < 512; a++) begin
            sd_buff_addr = 9'(a); sd_buff_dout = 8'(a) ^ 8'h5A; sd_buff_wr = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0; sd_ack = 1'b0;
        tick();
        check("rd_fin_nodone", {31'd0, hdd_done}, 32'd0);
        tick();
        check("rd_done", {27'd0, flags()}, 32'b01000);
        tick();
        check("rd_done_pulse", {31'd0, hdd_done}, 32'd0);
        hdd_ram_addr = 9'd7;
        tick();
        check("rd_ram7", {24'd0, hdd_ram_do}, 32'h5D);
        hdd_ram_addr = 9'h1FF;
        tick();
        check("rd_ram1ff", {24'd0, hdd_ram_do}, 32'hA5);

        // Write: controller fills 0xA5, then lba 9
        for (int a = 0; a < 512; a++) begin
            hdd_ram_addr = 9'(a); hdd_ram_di = 8'hA5; hdd_ram_we = 1'b1;
            tick();
        end
        hdd_ram_we = 1'b0;
        hdd_write = 1'b1; hdd_lba = 32'd9;
        tick();
        hdd_write = 1'b0;
        check("wr_lba", sd_lba, 32'd9);
        check("wr_flags", {27'd0, flags()}, 32'b10001);
        tick();
        sd_ack = 1'b1;
        tick();
        hdd_ram_addr = 9'd3; hdd_ram_di = 8'h11; hdd_ram_we = 1'b1;
        tick();
        hdd_ram_we = 1'b0;
        for (int a = 0; a < 512; a++) begin
            sd_buff_addr = 9'(a);
            tick();
            check("wr_din", {24'd0, sd_buff_din}, 32'hA5);
        end
        sd_ack = 1'b0;
        tick(); tick();
        check("wr_done", {27'd0, flags()}, 32'b01000);
        tick();
        check("wr_ctl_ignored", {24'd0, hdd_ram_do}, 32'hA5);

        // Protect error
        hdd_protect = 1'b1; hdd_write = 1'b1; hdd_lba = 32'd2;
        tick();
        hdd_write = 1'b0;
        check("prot_p1", {27'd0, flags()}, 32'b10000);
        tick();
        check("prot_done", {27'd0, flags()}, 32'b01100);
        tick();
        check("prot_sticky", {27'd0, flags()}, 32'b00100);

        // Mount error
        hdd_protect = 1'b0; hdd_mounted = 1'b0; hdd_read = 1'b1; hdd_lba = 32'd3;
        tick();
        hdd_read = 1'b0;
        check("mnt_p1", {27'd0, flags()}, 32'b10000);
        tick();
        check("mnt_done", {27'd0, flags()}, 32'b01100);
        hdd_mounted = 1'b1;

        // Queueing: lba 5 queued, lba 6 dropped
        hdd_read = 1'b1; hdd_lba = 32'h100;
        tick();
        hdd_read = 1'b0;
        check("q_err_clr", {31'd0, hdd_error}, 32'd0);
        tick();
        sd_ack = 1'b1;
        tick(); tick();
        hdd_read = 1'b1; hdd_lba = 32'd5;
        tick();
        hdd_lba = 32'd6;
        tick();
        hdd_read = 1'b0;
        tick();
        sd_ack = 1'b0;
        cw_drop = 1'b0;
        tick();
        if (!cpu_wait) cw_drop = 1'b1;
        tick();
        check("q_done1", {31'd0, hdd_done}, 32'd1);
        check("q_next_lba", sd_lba, 32'd5);
        check("q_next_rd", {31'd0, sd_rd}, 32'd1);
        if (!cpu_wait) cw_drop = 1'b1;
        tick();
        sd_ack = 1'b1;
        if (!cpu_wait) cw_drop = 1'b1;
        tick();
        sd_ack = 1'b0;
        if (!cpu_wait) cw_drop = 1'b1;
        tick();
        if (!cpu_wait) cw_drop = 1'b1;
        tick();
        check("q_cw_held", {31'd0, cw_drop}, 32'd0);
        check("q_done2", {27'd0, flags()}, 32'b01000);
        tick(); tick(); tick();
        check("q_no_third", {27'd0, flags()}, 32'd0);
        check("q_last_lba", sd_lba, 32'd5);

        // Reset mid-transfer, then stale ack and read+write together
        hdd_read = 1'b1; hdd_lba = 32'h77;
        tick();
        hdd_read = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_flags", {27'd0, flags()}, 32'd0);
        check("rst_async_lba", sd_lba, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        hdd_read = 1'b1; hdd_write = 1'b1; hdd_lba = 32'h42;
        tick();
        hdd_read = 1'b0; hdd_write = 1'b0;
        check("both_flags", {27'd0, flags()}, 32'b10010);
        tick(); tick();
        check("stale_ack_ignored", {31'd0, sd_rd}, 32'd1);
        sd_ack = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick();
        check("fresh_ack", {31'd0, sd_rd}, 32'd0);
        sd_ack = 1'b0;
        tick(); tick();
        check("both_done", {27'd0, flags()}, 32'b01000);

`ifdef HDD_TIMEOUT_EN
        begin
            int cyc;
            logic seen;
            seen = 1'b0;
            cyc = 0;
            hdd_read = 1'b1; hdd_lba = 32'h99;
            tick();
            hdd_read = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                tick();
                cyc++;
                if (hdd_done) seen = 1'b1;
            end
            check("tmo_seen", {31'd0, seen}, 32'd1);
            check("tmo_flags", {27'd0, flags()}, 32'b01100);
            check("tmo_near100", {31'd0, (cyc >= 95 && cyc <= 105)}, 32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
